// File: rtl/sd_pkg.sv
// Shared SD command-path definitions: frame geometry, CRC7 polynomial, transmitter
// state encoding and a single-bit CRC7 update used by both CMD transmit and receive.
package sd_pkg;

    localparam int         SD_CMD_FRAME_BITS   = 48;
    // Bits b47..b8 are covered by the CRC; the last 8 are CRC7 plus the end bit.
    localparam int         SD_CMD_PAYLOAD_BITS = SD_CMD_FRAME_BITS - 8;
    localparam logic [6:0] SD_CRC7_POLY        = 7'h09;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_SEND_ENC    = 3'd1;
    localparam logic [2:0] ST_CRC_ENC     = 3'd2;
    localparam logic [2:0] ST_END_ENC     = 3'd3;
    localparam logic [2:0] ST_RELEASE_ENC = 3'd4;
    localparam logic [2:0] ST_NCC_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_SEND    = ST_SEND_ENC,
        ST_CRC     = ST_CRC_ENC,
        ST_END     = ST_END_ENC,
        ST_RELEASE = ST_RELEASE_ENC,
        ST_NCC     = ST_NCC_ENC
    } tx_state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) accumulator, one data bit per enabled clock.
// Shared between the CMD transmitter and the response receiver.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [6:0] crc
);

    logic [6:0] crc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= 7'h00;
        end else if (clear) begin
            crc_reg <= 7'h00;
        end else if (enable) begin
            crc_reg <= crc7_step(crc_reg, data_in);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: serialises a 48-bit command frame one bit per SD clock tick,
// then idles the line for NCC_CYCLES ticks before pulsing cmd_done.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int NCC_CYCLES = 8
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        sd_clk_tick,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe
);

    tx_state_t   state_reg, state_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  ncc_cnt_reg, ncc_cnt_next;
    logic [37:0] shift_reg, shift_next;
    logic        out_reg, out_next;
    logic        oe_reg, oe_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        crc_clear;
    logic        crc_enable;
    logic        send_bit;
    logic [6:0]  crc;

    sd_crc7 u_crc7 (
        .clk     (hclk),
        .rst     (hrst),
        .clear   (crc_clear),
        .enable  (crc_enable),
        .data_in (send_bit),
        .crc     (crc)
    );

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 6'd0;
            ncc_cnt_reg <= 8'd0;
            shift_reg   <= 38'd0;
            out_reg     <= 1'b1;
            oe_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            ncc_cnt_reg <= ncc_cnt_next;
            shift_reg   <= shift_next;
            out_reg     <= out_next;
            oe_reg      <= oe_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Start and direction bits are constants; only index/arg live in the shift register.
    always_comb begin
        send_bit = shift_reg[37];
        if (bit_cnt_reg == 6'd0) begin
            send_bit = 1'b0;
        end else if (bit_cnt_reg == 6'd1) begin
            send_bit = 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        ncc_cnt_next = ncc_cnt_reg;
        shift_next   = shift_reg;
        out_next     = out_reg;
        oe_next      = oe_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        crc_clear    = 1'b0;
        crc_enable   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // busy_reg is still high in the cmd_done cycle, which blocks a same-cycle restart.
                busy_next = 1'b0;
                out_next  = 1'b1;
                oe_next   = 1'b0;
                if (cmd_start && !busy_reg) begin
                    shift_next   = {cmd_index, cmd_arg};
                    crc_clear    = 1'b1;
                    bit_cnt_next = 6'd0;
                    busy_next    = 1'b1;
                    state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sd_clk_tick) begin
                    out_next   = send_bit;
                    oe_next    = 1'b1;
                    crc_enable = 1'b1;
                    if (bit_cnt_reg >= 6'd2) begin
                        shift_next = {shift_reg[36:0], 1'b0};
                    end
                    if (bit_cnt_reg == 6'(SD_CMD_PAYLOAD_BITS - 1)) begin
                        bit_cnt_next = 6'd0;
                        state_next   = ST_CRC;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                    end
                end
            end
            ST_CRC: begin
                if (sd_clk_tick) begin
                    out_next = crc[3'd6 - bit_cnt_reg[2:0]];
                    if (bit_cnt_reg == 6'd6) begin
                        bit_cnt_next = 6'd0;
                        state_next   = ST_END;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                    end
                end
            end
            ST_END: begin
                if (sd_clk_tick) begin
                    out_next   = 1'b1;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (sd_clk_tick) begin
                    out_next     = 1'b1;
                    oe_next      = 1'b0;
                    ncc_cnt_next = 8'd1;
                    state_next   = ST_NCC;
                end
            end
            ST_NCC: begin
                if (sd_clk_tick) begin
                    if (ncc_cnt_reg == 8'(NCC_CYCLES)) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ncc_cnt_next = ncc_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                out_next   = 1'b1;
                oe_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign cmd_busy   = busy_reg;
    assign cmd_done   = done_reg;
    assign sd_cmd_out = out_reg;
    assign sd_cmd_oe  = oe_reg;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Scoreboard bench for sd_cmd_tx: stimulus queues expected frames, a line monitor
// reassembles each frame from the CMD pin and checks content, release and NCC timing.
module tb_sd_cmd_tx;

    localparam int NCC = 8;
    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_NCC   = 2;

    logic        hclk = 1'b0;
    logic        hrst = 1'b1;
    logic        sd_clk_tick = 1'b0;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        cmd_busy, cmd_done, sd_cmd_out, sd_cmd_oe;

    int          checks = 0;
    int          failures = 0;
    logic [47:0] exp_q[$];
    logic        tick_en = 1'b1;
    int          mon_bits = 0;
    int          mon_state = M_IDLE;
    int          frames_seen = 0;

    sd_cmd_tx #(.NCC_CYCLES(NCC)) dut (
        .hclk        (hclk),
        .hrst        (hrst),
        .sd_clk_tick (sd_clk_tick),
        .cmd_start   (cmd_start),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .cmd_busy    (cmd_busy),
        .cmd_done    (cmd_done),
        .sd_cmd_out  (sd_cmd_out),
        .sd_cmd_oe   (sd_cmd_oe)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One tick every 4 hclk while enabled; changes 1 time unit after the edge.
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge hclk);
            #1;
            if (tick_en) begin
                div = (div + 1) % 4;
                sd_clk_tick = (div == 0);
            end else begin
                sd_clk_tick = 1'b0;
            end
        end
    end

    // Line monitor: samples 2 time units after every edge.
    initial begin : monitor
        logic        tk;
        logic [47:0] frame;
        logic [47:0] exp_frame;
        logic        last_out;
        logic        hold_bad;
        logic        ncc_bad;
        logic        chk_fall;
        int          ncc_ticks;
        frame = 48'd0; last_out = 1'b1; hold_bad = 1'b0; ncc_bad = 1'b0;
        chk_fall = 1'b0; ncc_ticks = 0;
        forever begin
            @(posedge hclk);
            tk = sd_clk_tick;
            #2;
            if (hrst) begin
                mon_state = M_IDLE;
                mon_bits  = 0;
                chk_fall  = 1'b0;
                continue;
            end
            if (chk_fall) begin
                chk("busy_fall_after_done", cmd_busy, 0);
                chk("done_one_cycle", cmd_done, 0);
                chk_fall = 1'b0;
            end
            if (cmd_done && mon_state != M_NCC) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=1 required=0 state=%0d bits=%0d", mon_state, mon_bits);
            end
            if (mon_state == M_IDLE) begin
                if (sd_cmd_oe) begin
                    chk("oe_rise_on_tick", tk, 1);
                    mon_state = M_FRAME;
                    frame     = {47'd0, sd_cmd_out};
                    mon_bits  = 1;
                    hold_bad  = 1'b0;
                    last_out  = sd_cmd_out;
                end
            end else if (mon_state == M_FRAME) begin
                if (tk) begin
                    if (mon_bits < 48) begin
                        frame = {frame[46:0], sd_cmd_out};
                        mon_bits++;
                        if (!sd_cmd_oe) hold_bad = 1'b1;
                    end else begin
                        chk("release_oe", sd_cmd_oe, 0);
                        chk("release_out", sd_cmd_out, 1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL frame_unexpected actual=0x%012h required=none", frame);
                        end else begin
                            exp_frame = exp_q.pop_front();
                            chk("frame", frame, exp_frame);
                        end
                        chk("hold_between_ticks", hold_bad, 0);
                        mon_state = M_NCC;
                        ncc_ticks = 0;
                        ncc_bad   = 1'b0;
                    end
                end else if (sd_cmd_out !== last_out || sd_cmd_oe !== 1'b1) begin
                    hold_bad = 1'b1;
                end
                last_out = sd_cmd_out;
            end else begin
                if (tk) ncc_ticks++;
                if (sd_cmd_oe !== 1'b0 || sd_cmd_out !== 1'b1) ncc_bad = 1'b1;
                if (cmd_done) begin
                    chk("ncc_ticks_to_done", ncc_ticks, NCC);
                    chk("busy_during_done", cmd_busy, 1);
                    chk("line_idle_in_ncc", ncc_bad, 0);
                    frames_seen++;
                    $display("txn %0d frame=0x%012h ncc_ticks=%0d", frames_seen, frame, ncc_ticks);
                    mon_state = M_IDLE;
                    mon_bits  = 0;
                    chk_fall  = 1'b1;
                end else if (ncc_ticks > NCC) begin
                    chk("ncc_done_timeout", ncc_ticks, NCC);
                    mon_state = M_IDLE;
                    mon_bits  = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        @(posedge hclk); #1;
        while (cmd_busy && g < 5000) begin
            @(posedge hclk); #1;
            g++;
        end
        if (cmd_busy) chk("wait_idle_timeout", cmd_busy, 0);
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg,
                        input logic [47:0] exp, input bit push);
        wait_idle();
        cmd_index = idx;
        cmd_arg   = arg;
        cmd_start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge hclk); #1;
        cmd_start = 1'b0;
        cmd_index = ~idx;
        cmd_arg   = ~arg;
        chk("busy_after_accept", cmd_busy, 1);
    endtask

    task automatic wait_bits(input int n);
        int g;
        g = 0;
        while (mon_bits < n && g < 5000) begin
            @(posedge hclk);
            g++;
        end
        if (mon_bits < n) chk("wait_bits_timeout", mon_bits, n);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic held_out, held_oe;
        int   held_bits;
        int   g;

        repeat (3) @(posedge hclk);
        #1;
        chk("reset_out", sd_cmd_out, 1);
        chk("reset_oe", sd_cmd_oe, 0);
        chk("reset_busy", cmd_busy, 0);
        chk("reset_done", cmd_done, 0);
        #2 hrst = 1'b0;

        // CMD0, plain
        send(6'd0, 32'h0, 48'h40_00_00_00_00_95, 1);

        // CMD8 with ticks withheld mid-argument
        send(6'd8, 32'h1AA, 48'h48_00_00_01_AA_87, 1);
        wait_bits(20);
        @(posedge hclk); #3;
        tick_en = 1'b0;
        repeat (3) @(posedge hclk);
        #2;
        held_out  = sd_cmd_out;
        held_oe   = sd_cmd_oe;
        held_bits = mon_bits;
        repeat (100) @(posedge hclk);
        #2;
        chk("gated_out_hold", sd_cmd_out, held_out);
        chk("gated_oe", sd_cmd_oe, 1);
        chk("gated_bits_frozen", mon_bits, held_bits);
        chk("gated_busy", cmd_busy, 1);
        tick_en = 1'b1;

        // CMD17, with a CMD55 request mid-frame that must be dropped
        send(6'd17, 32'h0, 48'h51_00_00_00_00_55, 1);
        wait_bits(10);
        @(posedge hclk); #1;
        cmd_index = 6'd55;
        cmd_arg   = 32'h0;
        cmd_start = 1'b1;
        @(posedge hclk); #1;
        cmd_start = 1'b0;
        chk("busy_during_ignored_start", cmd_busy, 1);

        // CMD0 aborted by reset at bit 20
        send(6'd0, 32'h0, 48'h40_00_00_00_00_95, 0);
        wait_bits(20);
        @(posedge hclk); #3;
        hrst = 1'b1;
        #1;
        chk("abort_oe", sd_cmd_oe, 0);
        chk("abort_out", sd_cmd_out, 1);
        chk("abort_busy", cmd_busy, 0);
        chk("abort_done", cmd_done, 0);
        repeat (3) @(posedge hclk);
        #3 hrst = 1'b0;

        // Fresh CMD0 with cmd_start coincident with a tick
        wait_idle();
        g = 0;
        do begin
            @(posedge hclk); #2;
            g++;
        end while (!sd_clk_tick && g < 50);
        cmd_index = 6'd0;
        cmd_arg   = 32'h0;
        cmd_start = 1'b1;
        exp_q.push_back(48'h40_00_00_00_00_95);
        @(posedge hclk); #1;
        cmd_start = 1'b0;
        chk("coinc_busy", cmd_busy, 1);
        chk("coinc_tick_not_consumed", sd_cmd_oe, 0);
        g = 0;
        do begin
            @(posedge hclk);
            g++;
        end while (!sd_clk_tick && g < 50);
        #2;
        chk("coinc_start_bit_oe", sd_cmd_oe, 1);
        chk("coinc_start_bit_out", sd_cmd_out, 0);

        // CMD55, plain
        send(6'd55, 32'h0, 48'h77_00_00_00_00_65, 1);

        g = 0;
        while ((exp_q.size() != 0 || mon_state != M_IDLE || cmd_busy) && g < 10000) begin
            @(posedge hclk);
            g++;
        end
        repeat (4) @(posedge hclk);
        chk("queue_drained", exp_q.size(), 0);
        chk("frames_seen", frames_seen, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
